// File: rtl/vape_pkg.sv
// Shared types and defaults for the VAPE atomicity monitor.
// State encodings match the PoX exec-flag logic that sits beside it.
package vape_pkg;

  typedef enum logic [2:0] {
    NOTRC = 3'd0,
    FST   = 3'd1,
    LAST  = 3'd2,
    MID   = 3'd3,
    KILL  = 3'd4
  } er_state_e;

  localparam logic [15:0] SMEM_BASE_DEF = 16'hA000;
  localparam logic [15:0] SMEM_SIZE_DEF = 16'h4000;

endpackage

// File: rtl/vape_atomicity_multi_if.sv
// Bus between the MCU pc/bounds source and the atomicity monitor.
// Master drives pc, irq and bounds; slave returns per-region status.
interface vape_atomicity_multi_if #(
  parameter int N_ER  = 2,
  parameter int PC_W  = 16,
  parameter int CNT_W = 8
);

  logic [PC_W-1:0]       pc;
  logic                  irq;
  logic [N_ER*PC_W-1:0]  er_min;
  logic [N_ER*PC_W-1:0]  er_max;
  logic                  clr_cnt;
  logic [N_ER-1:0]       exec;
  logic [N_ER-1:0]       viol;
  logic [N_ER*CNT_W-1:0] viol_cnt;

  modport master (
    output pc, irq, er_min, er_max, clr_cnt,
    input  exec, viol, viol_cnt
  );

  modport slave (
    input  pc, irq, er_min, er_max, clr_cnt,
    output exec, viol, viol_cnt
  );

endinterface

// File: rtl/vape_er_fsm.sv
// One executable region: pc classification, entry/exit FSM,
// and a saturating violation counter.
module vape_er_fsm
  import vape_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              CNT_W     = 8,
  parameter logic [PC_W-1:0] SMEM_BASE = SMEM_BASE_DEF,
  parameter logic [PC_W-1:0] SMEM_SIZE = SMEM_SIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             irq_kill_i,
  input  logic [PC_W-1:0]  min_i,
  input  logic [PC_W-1:0]  max_i,
  input  logic             clr_cnt_i,
  output logic             exec_o,
  output logic             viol_o,
  output logic [CNT_W-1:0] cnt_o
);

  // One bit wider so the end of SMEM never wraps to zero
  localparam logic [PC_W:0] SMEM_END =
    {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

  er_state_e        state_q, next_d;
  logic [CNT_W-1:0] cnt_q;
  logic             first, last, mid, out, valid;

  assign first = (pc_i == min_i);
  assign last  = (pc_i == max_i);
  assign mid   = (pc_i > min_i) && (pc_i < max_i);
  assign out   = (pc_i < min_i) || (pc_i > max_i);

  assign valid = (min_i < max_i) &&
                 ((max_i < SMEM_BASE) ||
                  ({1'b0, min_i} > SMEM_END));

  always_comb begin
    next_d = KILL;
    unique case (state_q)
      NOTRC: begin
        if (out)        next_d = NOTRC;
        else if (first) next_d = FST;
      end
      FST: begin
        if (first)    next_d = FST;
        else if (mid) next_d = MID;
      end
      MID: begin
        if (mid)       next_d = MID;
        else if (last) next_d = LAST;
      end
      LAST: begin
        if (last)     next_d = LAST;
        else if (out) next_d = NOTRC;
      end
      default: begin
        if (first) next_d = FST;
      end
    endcase
    if (irq_kill_i && (state_q == FST || state_q == MID))
      next_d = KILL;
    if (!valid)
      next_d = KILL;
  end

  assign exec_o = !reset && valid && (next_d != KILL);
  assign viol_o = !reset && valid &&
                  (next_d == KILL) && (state_q != KILL);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= KILL;
      cnt_q   <= '0;
    end else begin
      state_q <= next_d;
      if (clr_cnt_i)
        cnt_q <= '0;
      else if (viol_o && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/vape_atomicity_multi.sv
// N-region atomicity monitor: slices the packed bounds per region
// and applies the irq-kill policy before handing irq to each FSM.
module vape_atomicity_multi
  import vape_pkg::*;
#(
  parameter int              N_ER      = 2,
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] SMEM_BASE = SMEM_BASE_DEF,
  parameter logic [PC_W-1:0] SMEM_SIZE = SMEM_SIZE_DEF,
  parameter bit              IRQ_KILL  = 1'b1,
  parameter int              CNT_W     = 8
) (
  input logic                   clk,
  input logic                   reset,
  vape_atomicity_multi_if.slave bus
);

  logic irq_kill;
  wire [N_ER-1:0]       exec_w;
  wire [N_ER-1:0]       viol_w;
  wire [N_ER*CNT_W-1:0] cnt_w;

  assign irq_kill = IRQ_KILL & bus.irq;

  for (genvar i = 0; i < N_ER; i++) begin : g_er
    vape_er_fsm #(
      .PC_W      (PC_W),
      .CNT_W     (CNT_W),
      .SMEM_BASE (SMEM_BASE),
      .SMEM_SIZE (SMEM_SIZE)
    ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .pc_i       (bus.pc),
      .irq_kill_i (irq_kill),
      .min_i      (bus.er_min[i*PC_W +: PC_W]),
      .max_i      (bus.er_max[i*PC_W +: PC_W]),
      .clr_cnt_i  (bus.clr_cnt),
      .exec_o     (exec_w[i]),
      .viol_o     (viol_w[i]),
      .cnt_o      (cnt_w[i*CNT_W +: CNT_W])
    );
  end

  assign bus.exec     = exec_w;
  assign bus.viol     = viol_w;
  assign bus.viol_cnt = cnt_w;

endmodule

// File: tb/tb_vape_atomicity_multi.sv
// Directed bench: dut (IRQ_KILL=1, CNT_W=8) and dut2 (IRQ_KILL=0,
// CNT_W=2) share one stimulus stream. SMEM is A000..CFFF here.
module tb_vape_atomicity_multi;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] e1_lo, e1_hi;

  always #5 clk = ~clk;

  vape_atomicity_multi_if #(.N_ER(2), .PC_W(16), .CNT_W(8)) bus ();
  vape_atomicity_multi_if #(.N_ER(2), .PC_W(16), .CNT_W(2)) bus2 ();

  assign bus2.pc      = bus.pc;
  assign bus2.irq     = bus.irq;
  assign bus2.er_min  = bus.er_min;
  assign bus2.er_max  = bus.er_max;
  assign bus2.clr_cnt = bus.clr_cnt;

  vape_atomicity_multi #(
    .N_ER(2), .PC_W(16), .SMEM_BASE(16'hA000),
    .SMEM_SIZE(16'h3000), .IRQ_KILL(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vape_atomicity_multi #(
    .N_ER(2), .PC_W(16), .SMEM_BASE(16'hA000),
    .SMEM_SIZE(16'h3000), .IRQ_KILL(1'b0), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] p,
                       input logic i,
                       input logic c);
    @(negedge clk);
    bus.pc      = p;
    bus.irq     = i;
    bus.clr_cnt = c;
    bus.er_min  = {e1_lo, 16'hE000};
    bus.er_max  = {e1_hi, 16'hE0FE};
    #1;
  endtask

  initial begin
    reset = 1'b1;
    e1_lo = 16'h4000;
    e1_hi = 16'h4010;
    bus.pc = 16'h1000;
    bus.irq = 1'b0;
    bus.clr_cnt = 1'b0;
    bus.er_min = {e1_lo, 16'hE000};
    bus.er_max = {e1_hi, 16'hE0FE};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_exec", 32'(bus.exec), 32'h0);
    chk("rst_viol", 32'(bus.viol), 32'h0);
    chk("rst_cnt", 32'(bus.viol_cnt), 32'h0);
    reset = 1'b0;

    // legal run through ER0
    drive(16'h1000, 0, 0);
    chk("post_rst_exec", 32'(bus.exec), 32'h0);
    drive(16'hE000, 0, 0);
    chk("fst_exec", 32'(bus.exec), 32'h1);
    drive(16'hE010, 0, 0);
    chk("st_fst", 32'(dut.g_er[0].u_fsm.state_q), 32'd1);
    chk("mid_exec", 32'(bus.exec[0]), 32'h1);
    drive(16'hE0FE, 0, 0);
    chk("st_mid", 32'(dut.g_er[0].u_fsm.state_q), 32'd3);
    chk("last_exec", 32'(bus.exec[0]), 32'h1);
    drive(16'h1002, 0, 0);
    chk("st_last", 32'(dut.g_er[0].u_fsm.state_q), 32'd2);
    chk("exit_exec", 32'(bus.exec[0]), 32'h1);
    chk("exit_viol", 32'(bus.viol), 32'h0);
    drive(16'h1002, 0, 0);
    chk("st_notrc", 32'(dut.g_er[0].u_fsm.state_q), 32'd0);
    chk("notrc_exec", 32'(bus.exec[0]), 32'h1);

    // mid-entry
    drive(16'hE010, 0, 0);
    chk("me_exec", 32'(bus.exec[0]), 32'h0);
    chk("me_viol", 32'(bus.viol), 32'h1);
    chk("me_cnt_pre", 32'(bus.viol_cnt[7:0]), 32'h0);
    drive(16'h1002, 0, 0);
    chk("me_viol_end", 32'(bus.viol), 32'h0);
    chk("me_cnt", 32'(bus.viol_cnt[7:0]), 32'h1);
    chk("me_cnt2", 32'(bus2.viol_cnt[1:0]), 32'h1);
    drive(16'hE000, 0, 0);
    chk("reentry_exec", 32'(bus.exec[0]), 32'h1);

    // irq inside ER0
    drive(16'hE010, 0, 0);
    drive(16'hE010, 1, 0);
    chk("irq_exec", 32'(bus.exec[0]), 32'h0);
    chk("irq_viol", 32'(bus.viol[0]), 32'h1);
    chk("irq_exec_nk", 32'(bus2.exec[0]), 32'h1);
    chk("irq_viol_nk", 32'(bus2.viol[0]), 32'h0);
    drive(16'hE0FE, 0, 0);
    chk("irq_cnt", 32'(bus.viol_cnt[7:0]), 32'h2);
    chk("kill_last", 32'(bus.exec[0]), 32'h0);
    chk("nk_last", 32'(bus2.exec[0]), 32'h1);
    drive(16'h1002, 0, 0);
    chk("nk_cnt", 32'(bus2.viol_cnt[1:0]), 32'h1);

    // ER1 legal, then invalid bounds
    drive(16'h4000, 0, 0);
    chk("er1_exec", 32'(bus.exec[1]), 32'h1);
    e1_lo = 16'hA100;
    e1_hi = 16'hA200;
    drive(16'hA100, 0, 0);
    chk("smem_exec", 32'(bus.exec[1]), 32'h0);
    chk("smem_viol", 32'(bus.viol[1]), 32'h0);
    drive(16'hA200, 0, 0);
    chk("smem_exec2", 32'(bus.exec[1]), 32'h0);
    drive(16'h1000, 0, 0);
    chk("smem_cnt", 32'(bus.viol_cnt[15:8]), 32'h0);
    e1_lo = 16'h5000;
    e1_hi = 16'h5000;
    drive(16'h5000, 0, 0);
    chk("eq_exec", 32'(bus.exec[1]), 32'h0);
    chk("eq_viol", 32'(bus.viol[1]), 32'h0);

    // bound change into KILL
    e1_lo = 16'h4000;
    e1_hi = 16'h4010;
    drive(16'h4000, 0, 0);
    chk("bc_fst", 32'(bus.exec[1]), 32'h1);
    drive(16'h4005, 0, 0);
    chk("bc_mid", 32'(bus.exec[1]), 32'h1);
    e1_lo = 16'h4006;
    drive(16'h4005, 0, 0);
    chk("bc_exec", 32'(bus.exec[1]), 32'h0);
    chk("bc_viol", 32'(bus.viol[1]), 32'h1);
    drive(16'h1000, 0, 0);
    chk("bc_cnt", 32'(bus.viol_cnt[15:8]), 32'h1);

    // SMEM edge: end is D000, strict compare
    e1_lo = 16'hD000;
    e1_hi = 16'hD010;
    drive(16'hD000, 0, 0);
    chk("edge_end", 32'(bus.exec[1]), 32'h0);
    e1_lo = 16'hD001;
    drive(16'hD001, 0, 0);
    chk("edge_end1", 32'(bus.exec[1]), 32'h1);
    e1_lo = 16'h9000;
    e1_hi = 16'hA000;
    drive(16'h9000, 0, 0);
    chk("edge_base", 32'(bus.exec[1]), 32'h0);
    chk("edge_base_v", 32'(bus.viol[1]), 32'h0);
    e1_hi = 16'h9FFF;
    drive(16'h9000, 0, 0);
    chk("edge_base1", 32'(bus.exec[1]), 32'h1);
    e1_lo = 16'h4000;
    e1_hi = 16'h4010;

    // saturation with CNT_W=2
    drive(16'h1000, 0, 1);
    drive(16'h1000, 0, 0);
    chk("clr_cnt", 32'(bus.viol_cnt[7:0]), 32'h0);
    chk("clr_cnt2", 32'(bus2.viol_cnt[1:0]), 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(16'hE000, 0, 0);
      drive(16'h1000, 0, 0);
      chk("sat_viol", 32'(bus2.viol[0]), 32'h1);
    end
    drive(16'h1000, 0, 0);
    chk("sat_cnt2", 32'(bus2.viol_cnt[1:0]), 32'h3);
    chk("sat_cnt", 32'(bus.viol_cnt[7:0]), 32'h5);

    // clear wins over increment
    drive(16'hE000, 0, 0);
    drive(16'h1000, 0, 1);
    chk("clrv_viol", 32'(bus.viol[0]), 32'h1);
    drive(16'h1000, 0, 0);
    chk("clrv_cnt", 32'(bus.viol_cnt[7:0]), 32'h0);
    chk("clrv_cnt2", 32'(bus2.viol_cnt[1:0]), 32'h0);

    // reset while in MID
    drive(16'hE000, 0, 0);
    drive(16'hE010, 0, 0);
    chk("pre_rst_mid", 32'(bus.exec[0]), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmid_exec", 32'(bus.exec), 32'h0);
    chk("rmid_viol", 32'(bus.viol), 32'h0);
    chk("rmid_exec2", 32'(bus2.exec), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.pc = 16'hE011;
    #1;
    chk("rel_exec", 32'(bus.exec[0]), 32'h0);
    chk("rel_viol", 32'(bus.viol[0]), 32'h0);
    drive(16'hE0FE, 0, 0);
    chk("rel_last", 32'(bus.exec[0]), 32'h0);
    drive(16'hE000, 0, 0);
    chk("rel_entry", 32'(bus.exec[0]), 32'h1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
